stage_waveform_generator_multi: RTL and testbench
=================================================

Name: stage_waveform_generator_multi

Overview:
Parametrised successor to the operator waveform stage. It converts an operator phase word into a signed waveform sample using a quarter-wave table, and passes a generic sideband bundle (voice/operator ID, algorithm word, note-on) through with matching latency. The quarter-wave table is a RAM loaded by the host/boot loader through a write port, tracked by a small load state machine, instead of a ROM image. The block sits between the phase accumulator stage and the envelope/mix stage.

Parameters:
PHASE_WIDTH, 17, phase word width; MSB is the sign bit and is ignored.
TABLE_ADDR_BITS, 14, quarter-wave table address width; depth = 2**TABLE_ADDR_BITS.
OUT_WIDTH, 16, signed output width; table entries are OUT_WIDTH-1 bits (unsigned magnitude).
SIDEBAND_WIDTH, 32, width of the pass-through sideband bundle.

Ports:
i_Clock  in  1  clock
i_Reset  in  1  asynchronous, active-high reset
i_Valid  in  1  input sample valid
i_Phase  in  PHASE_WIDTH  phase word
i_Mode  in  2  waveform select (only used with the optional feature)
i_Sideband  in  SIDEBAND_WIDTH  opaque data, delayed to match the output
i_TableWrite  in  1  table write strobe
i_TableAddr  in  TABLE_ADDR_BITS  table write address
i_TableData  in  OUT_WIDTH-1  table write data
i_TableReload  in  1  single-cycle pulse; returns the block to the load state
o_TableReady  out  1  table fully loaded; lookups enabled
o_Valid  out  1  output sample valid
o_Waveform  out  OUT_WIDTH  signed sample
o_Sideband  out  SIDEBAND_WIDTH  delayed sideband

Behaviour:
- Reset, asynchronous and active-high: o_Valid=0, o_Waveform=0, o_Sideband=0, o_TableReady=0, all pipeline valid bits=0, FSM=LOADING. Table contents are not reset.
- Phase decode: P=PHASE_WIDTH.
  - NegOut = i_Phase[P-2].
  - Mirror = i_Phase[P-3].
  - Arg = i_Phase[P-4 -: TABLE_ADDR_BITS].
  - Lower bits are ignored.
  - Elaboration error if P-3 < TABLE_ADDR_BITS.
- Pipeline: fixed 3-cycle latency, no backpressure, advances every clock.
  - Stage 1 registers NegOut and Addr = Mirror ? ~Arg : Arg.
  - Stage 2 registers the table read (synchronous read).
  - Stage 3 sets o_Waveform = NegOut ? ~{1'b0,mag} : {1'b0,mag}. This is one's-complement negation: no +1, and no asymmetry handling.
- Valid and sideband travel alongside the sample. o_Valid(t+3) = i_Valid(t) AND FSM==READY at t.
- When o_Valid=0, o_Waveform and o_Sideband hold their previous values.
- Load FSM:
  - LOADING: any i_TableWrite writes the table. A write to address 2**TABLE_ADDR_BITS-1 moves the FSM to READY on the next cycle, and o_TableReady goes to 1 at the same edge. Inputs with i_Valid=1 are dropped.
  - READY: i_TableWrite is ignored, so the table is read-only and there are no read/write collisions.
  - i_TableReload in READY moves the FSM to LOADING and clears all in-flight pipeline valid bits at that edge (squash). o_TableReady drops at the same edge.
  - i_TableReload in LOADING is ignored.
- Simultaneous events:
  - Write to the last address together with i_Valid in LOADING: the write completes and the sample is dropped.
  - Reload together with i_Valid in READY: the sample is dropped.
- Reset mid-load: the FSM returns to LOADING. A full reload (a write to the last address) is required before READY is reached again.

Optional Feature:
Macro: WAVEGEN_ALT_WAVEFORMS_EN.
- Defined: i_Mode is sampled at stage 1 and piped with the sample.
  - 0 = sine (table).
  - 1 = square: ~0 magnitude, i.e. 0x7FFF / 0x8000 at defaults.
  - 2 = saw: o_Waveform = i_Phase[P-2 -: OUT_WIDTH] with the MSB inverted (zero-padded if short). Phase 0 gives the minimum; full scale gives the maximum.
  - 3 = triangle: magnitude = Addr left-justified in OUT_WIDTH-1 bits with zero LSBs, then the same NegOut rule as sine.
  - Latency stays 3 cycles.
- Undefined: i_Mode is ignored (port kept, unused; lint waiver) and sine only.

Test Plan:
1. Reset, then load table[a]=a for all 16384 entries. o_TableReady stays 0 until the write to 0x3FFF, then reads 1 on the next cycle. Inputs with i_Valid=1 during the load produce no o_Valid.
2. Ramp table loaded. Send phases 0x00005, 0x04005, 0x08005, 0x0C005, 0x1C005 on consecutive cycles. Outputs exactly 3 cycles later: 0x0005, 0x3FFA, 0xFFFA, 0xC005, 0xC005 (sign bit ignored).
3. Sideband 0xDEADBEEF with i_Valid=1 appears on o_Sideband with o_Valid=1 three cycles later. Gaps with i_Valid=0 produce o_Valid=0 and hold the previous outputs.
4. Three valid samples in flight, then pulse i_TableReload. No o_Valid follows, o_TableReady=0, and writes are accepted again. A READY-state write beforehand leaves the table unchanged.
5. Assert i_Reset asynchronously mid-pipeline. Outputs read 0 immediately, without waiting for a clock edge, and the FSM is in LOADING.
6. With WAVEGEN_ALT_WAVEFORMS_EN defined, phase 0x04000:
   - Mode 1 gives 0x7FFF; 0x0C000 gives 0x8000.
   - Mode 2 gives 0xC000.
   - Mode 3 gives 0x7FFE.

Source files
------------

// File: rtl/stage_waveform_generator_multi.sv
// ============================================================================
// Module   : stage_waveform_generator_multi
// Purpose  : Phase word -> signed waveform sample via a host-loaded quarter-
//            wave RAM, 3-cycle pipeline with matched valid/sideband.
//            Optional alternate waveforms: WAVEGEN_ALT_WAVEFORMS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_waveform_generator_multi #(
    parameter int PHASE_WIDTH     = 17,
    parameter int TABLE_ADDR_BITS = 14,
    parameter int OUT_WIDTH       = 16,
    parameter int SIDEBAND_WIDTH  = 32
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Valid,
    input  logic [PHASE_WIDTH-1:0]     i_Phase,
    input  logic [1:0]                 i_Mode,
    input  logic [SIDEBAND_WIDTH-1:0]  i_Sideband,
    input  logic                       i_TableWrite,
    input  logic [TABLE_ADDR_BITS-1:0] i_TableAddr,
    input  logic [OUT_WIDTH-2:0]       i_TableData,
    input  logic                       i_TableReload,
    output logic                       o_TableReady,
    output logic                       o_Valid,
    output logic [OUT_WIDTH-1:0]       o_Waveform,
    output logic [SIDEBAND_WIDTH-1:0]  o_Sideband
);

    localparam int MAG_W = OUT_WIDTH - 1;
    localparam int DEPTH = 2 ** TABLE_ADDR_BITS;
    localparam logic [TABLE_ADDR_BITS-1:0] c_LAST_ADDR = '1;

    if (PHASE_WIDTH - 3 < TABLE_ADDR_BITS) begin : g_bad_params
        $error("PHASE_WIDTH-3 must be >= TABLE_ADDR_BITS");
    end

    typedef enum logic [0:0] {LOADING = 1'b0, READY = 1'b1} state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_table_we;
    logic   w_accept;
    logic   w_squash;

    logic [MAG_W-1:0] r_mem [DEPTH];
    logic [MAG_W-1:0] r_rd;

    logic                       r_v1, r_v2;
    logic                       r_neg1, r_neg2;
    logic [TABLE_ADDR_BITS-1:0] r_addr1;
    logic [SIDEBAND_WIDTH-1:0]  r_sb1, r_sb2;
    logic [OUT_WIDTH-1:0]       w_wave;
    logic [MAG_W-1:0]           w_mag;

    // Sign bit and sub-table phase bits carry no information here.
    wire unused_inputs = ^{i_Phase, i_Mode};

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) r_state <= LOADING;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_table_we   = 1'b0;
        w_accept     = 1'b0;
        w_squash     = 1'b0;
        case (r_state)
            LOADING: begin
                w_table_we = i_TableWrite;
                if (i_TableWrite && (i_TableAddr == c_LAST_ADDR))
                    w_state_next = READY;
            end
            READY: begin
                w_squash = i_TableReload;
                w_accept = i_Valid && !i_TableReload;
                if (i_TableReload)
                    w_state_next = LOADING;
            end
            default: w_state_next = LOADING;
        endcase
    end

    assign o_TableReady = (r_state == READY);

    // Table RAM is deliberately outside the reset domain.
    always_ff @(posedge i_Clock) begin
        if (w_table_we)
            r_mem[i_TableAddr] <= i_TableData;
        r_rd <= r_mem[r_addr1];
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_v1    <= 1'b0;
            r_neg1  <= 1'b0;
            r_addr1 <= '0;
            r_sb1   <= '0;
            r_v2    <= 1'b0;
            r_neg2  <= 1'b0;
            r_sb2   <= '0;
            o_Valid    <= 1'b0;
            o_Waveform <= '0;
            o_Sideband <= '0;
        end else begin
            r_v1    <= w_accept;
            r_neg1  <= i_Phase[PHASE_WIDTH-2];
            r_addr1 <= i_Phase[PHASE_WIDTH-3]
                     ? ~i_Phase[PHASE_WIDTH-4 -: TABLE_ADDR_BITS]
                     :  i_Phase[PHASE_WIDTH-4 -: TABLE_ADDR_BITS];
            r_sb1   <= i_Sideband;
            r_v2    <= r_v1 && !w_squash;
            r_neg2  <= r_neg1;
            r_sb2   <= r_sb1;
            o_Valid <= r_v2 && !w_squash;
            if (r_v2 && !w_squash) begin
                o_Waveform <= w_wave;
                o_Sideband <= r_sb2;
            end
        end
    end

`ifdef WAVEGEN_ALT_WAVEFORMS_EN
    logic [1:0]                 r_mode1, r_mode2;
    logic [OUT_WIDTH-1:0]       r_saw1, r_saw2;
    logic [TABLE_ADDR_BITS-1:0] r_addr2;
    logic [OUT_WIDTH-1:0]       w_saw;
    logic [MAG_W-1:0]           w_tri;

    if (PHASE_WIDTH - 1 >= OUT_WIDTH) begin : g_saw_slice
        assign w_saw = i_Phase[PHASE_WIDTH-2 -: OUT_WIDTH];
    end else begin : g_saw_pad
        assign w_saw = {i_Phase[PHASE_WIDTH-2:0], {(OUT_WIDTH-PHASE_WIDTH+1){1'b0}}};
    end

    if (MAG_W > TABLE_ADDR_BITS) begin : g_tri_pad
        assign w_tri = {r_addr2, {(MAG_W-TABLE_ADDR_BITS){1'b0}}};
    end else begin : g_tri_slice
        assign w_tri = r_addr2[TABLE_ADDR_BITS-1 -: MAG_W];
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_mode1 <= 2'd0;
            r_mode2 <= 2'd0;
            r_saw1  <= '0;
            r_saw2  <= '0;
            r_addr2 <= '0;
        end else begin
            r_mode1 <= i_Mode;
            r_mode2 <= r_mode1;
            // Inverting the MSB maps phase 0 to the most negative sample.
            r_saw1  <= {~w_saw[OUT_WIDTH-1], w_saw[OUT_WIDTH-2:0]};
            r_saw2  <= r_saw1;
            r_addr2 <= r_addr1;
        end
    end

    always_comb begin
        w_mag = r_rd;
        case (r_mode2)
            2'd1:    w_mag = '1;
            2'd3:    w_mag = w_tri;
            default: w_mag = r_rd;
        endcase
        w_wave = r_neg2 ? ~{1'b0, w_mag} : {1'b0, w_mag};
        if (r_mode2 == 2'd2)
            w_wave = r_saw2;
    end
`else
    always_comb begin
        w_mag  = r_rd;
        w_wave = r_neg2 ? ~{1'b0, w_mag} : {1'b0, w_mag};
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stage_waveform_generator_multi.sv
// ============================================================================
// Module   : tb_stage_waveform_generator_multi
// Purpose  : Directed self-checking bench for stage_waveform_generator_multi.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_waveform_generator_multi;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [16:0] phase;
    logic [1:0]  mode;
    logic [31:0] sb_in;
    logic        twrite;
    logic [13:0] taddr;
    logic [14:0] tdata;
    logic        reload;
    logic        ready;
    logic        valid_out;
    logic [15:0] wave;
    logic [31:0] sb_out;

    int checks   = 0;
    int failures = 0;
    int seen;

    stage_waveform_generator_multi dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Valid       (valid_in),
        .i_Phase       (phase),
        .i_Mode        (mode),
        .i_Sideband    (sb_in),
        .i_TableWrite  (twrite),
        .i_TableAddr   (taddr),
        .i_TableData   (tdata),
        .i_TableReload (reload),
        .o_TableReady  (ready),
        .o_Valid       (valid_out),
        .o_Waveform    (wave),
        .o_Sideband    (sb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one valid sample, then idle until it reaches the output.
    task automatic one_sample(input logic [16:0] ph, input logic [1:0] md, input logic [31:0] sb);
        phase = ph; mode = md; sb_in = sb; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
    endtask

    logic [16:0] ph_vec  [5] = '{17'h00005, 17'h04005, 17'h08005, 17'h0C005, 17'h1C005};
    logic [15:0] exp_vec [5] = '{16'h0005, 16'h3FFA, 16'hFFFA, 16'hC005, 16'hC005};

    initial begin
        rst = 1'b1; valid_in = 1'b0; phase = '0; mode = 2'd0; sb_in = '0;
        twrite = 1'b0; taddr = '0; tdata = '0; reload = 1'b0;
        #1;
        check("reset_valid", {63'd0, valid_out}, 64'd0);
        check("reset_wave", {48'd0, wave}, 64'd0);
        check("reset_sb", {32'd0, sb_out}, 64'd0);
        check("reset_ready", {63'd0, ready}, 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Ramp load with valid samples offered throughout (all must drop)
        seen = 0;
        valid_in = 1'b1; phase = 17'h00005; sb_in = 32'hCAFE0000;
        for (int a = 0; a < 16384; a++) begin
            twrite = 1'b1; taddr = 14'(a); tdata = 15'(a);
            if (a == 100)   check("load_ready_mid", {63'd0, ready}, 64'd0);
            if (a == 16383) check("load_ready_last_pre", {63'd0, ready}, 64'd0);
            tick();
            if (valid_out) seen++;
        end
        twrite = 1'b0; valid_in = 1'b0;
        check("load_ready_after", {63'd0, ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (valid_out) seen++;
        end
        check("load_dropped_valid", 64'(seen), 64'd0);

        // Back-to-back phases covering all four quadrants
        for (int j = 0; j < 8; j++) begin
            if (j < 5) begin
                phase = ph_vec[j]; sb_in = 32'h1000 + 32'(j); valid_in = 1'b1;
            end else begin
                valid_in = 1'b0; phase = 17'h0ABCD; sb_in = 32'hFFFF_FFFF;
            end
            tick();
            if (j >= 2 && j <= 6) begin
                check($sformatf("quad_valid_%0d", j-2), {63'd0, valid_out}, 64'd1);
                check($sformatf("quad_wave_%0d", j-2), {48'd0, wave}, {48'd0, exp_vec[j-2]});
                check($sformatf("quad_sb_%0d", j-2), {32'd0, sb_out}, {32'd0, 32'h1000 + 32'(j-2)});
            end
        end
        check("gap_valid", {63'd0, valid_out}, 64'd0);
        check("gap_hold_wave", {48'd0, wave}, 64'hC005);
        check("gap_hold_sb", {32'd0, sb_out}, 64'h1004);

        // Sideband passthrough then hold
        one_sample(17'h00005, 2'd0, 32'hDEADBEEF);
        sb_in = 32'h12345678; phase = 17'h08000;
        check("sb_valid", {63'd0, valid_out}, 64'd1);
        check("sb_value", {32'd0, sb_out}, 64'hDEADBEEF);
        tick();
        check("sb_gap_valid", {63'd0, valid_out}, 64'd0);
        check("sb_hold", {32'd0, sb_out}, 64'hDEADBEEF);
        check("sb_hold_wave", {48'd0, wave}, 64'h0005);

        // Write in READY is ignored
        twrite = 1'b1; taddr = 14'd5; tdata = 15'h7777;
        tick();
        twrite = 1'b0;
        one_sample(17'h00005, 2'd0, 32'hA5);
        check("ready_write_ignored", {48'd0, wave}, 64'h0005);

        // Reload squashes samples in flight
        phase = 17'h00005; sb_in = 32'hBAD; valid_in = 1'b1;
        tick();
        tick();
        reload = 1'b1;
        tick();
        reload = 1'b0; valid_in = 1'b0;
        check("reload_ready", {63'd0, ready}, 64'd0);
        check("reload_squash_now", {63'd0, valid_out}, 64'd0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (valid_out) seen++;
        end
        check("reload_squash_after", 64'(seen), 64'd0);

        // Reload pulse while LOADING is ignored; writes accepted again
        twrite = 1'b1; taddr = 14'd5; tdata = 15'h0100; reload = 1'b1;
        tick();
        reload = 1'b0; taddr = 14'h3FFF; tdata = 15'h3FFF;
        check("reload_loading_pre", {63'd0, ready}, 64'd0);
        tick();
        twrite = 1'b0;
        check("reload_ready_again", {63'd0, ready}, 64'd1);
        one_sample(17'h00005, 2'd0, 32'hB0);
        check("reload_new_data", {48'd0, wave}, 64'h0100);

        // Asynchronous reset mid-pipeline
        phase = 17'h08005; sb_in = 32'h55; valid_in = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_valid", {63'd0, valid_out}, 64'd1);
        check("pre_rst_wave", {48'd0, wave}, 64'hFEFF);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, valid_out}, 64'd0);
        check("async_rst_wave", {48'd0, wave}, 64'd0);
        check("async_rst_sb", {32'd0, sb_out}, 64'd0);
        check("async_rst_ready", {63'd0, ready}, 64'd0);
        tick();
        rst = 1'b0; valid_in = 1'b0;
        twrite = 1'b1; taddr = 14'd0; tdata = 15'd0;
        tick();
        twrite = 1'b0;
        check("rst_partial_load", {63'd0, ready}, 64'd0);
        twrite = 1'b1; taddr = 14'h3FFF; tdata = 15'h3FFF;
        tick();
        twrite = 1'b0;
        check("rst_full_load", {63'd0, ready}, 64'd1);
        one_sample(17'h00005, 2'd0, 32'hC0);
        check("table_survives_rst", {48'd0, wave}, 64'h0100);

`ifdef WAVEGEN_ALT_WAVEFORMS_EN
        one_sample(17'h04000, 2'd1, 32'h1);
        check("alt_square_pos", {48'd0, wave}, 64'h7FFF);
        one_sample(17'h0C000, 2'd1, 32'h2);
        check("alt_square_neg", {48'd0, wave}, 64'h8000);
        one_sample(17'h04000, 2'd2, 32'h3);
        check("alt_saw", {48'd0, wave}, 64'hC000);
        one_sample(17'h00000, 2'd2, 32'h4);
        check("alt_saw_min", {48'd0, wave}, 64'h8000);
        one_sample(17'h04000, 2'd3, 32'h5);
        check("alt_triangle", {48'd0, wave}, 64'h7FFE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
